// File: rtl/heu_win_rx.sv
// heu_win_rx
// Receives 80-pixel chunks from the IPGU output buffer and collects five
// of them into a 20x20 window (400 pixels). Two windows are held in a
// ping-pong buffer. Each complete window is streamed to the HEU datapath
// one pixel per cycle.
//
// Ports:
//   clk             clock
//   rst             asynchronous reset, active-high
//   vldIpgu         IPGU presents a chunk on ipguOutBufferQ
//   ipguOutBufferQ  chunk data, element 0 is the earliest pixel
//   rdyHeu          one-cycle registered accept pulse back to the IPGU
//   flush           synchronous clear of buffers and counters
//   pxOut           current output pixel (0 while pxVld is low)
//   pxVld / pxRdy   output valid/ready handshake
//   pxFirst         pxOut is pixel 0 of a window (qualified by pxVld)
//   pxLast          pxOut is pixel 399 of a window (qualified by pxVld)
//   winCnt          windows fully streamed out, wraps modulo 2^16
//
// Capture FSM:
//   state  | meaning
//   C_WAIT | waiting for vldIpgu while a free buffer exists
//   C_ACK  | rdyHeu high; the chunk is written on this edge
//   C_GAP  | one idle cycle so the IPGU can leave its wait state

module heu_win_rx #(
    parameter int PIX_W          = 8,
    parameter int CHUNK_LEN      = 80,
    parameter int CHUNKS_PER_WIN = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vldIpgu,
    input  logic [PIX_W-1:0] ipguOutBufferQ [CHUNK_LEN-1:0],
    output logic             rdyHeu,
    input  logic             flush,
    output logic [PIX_W-1:0] pxOut,
    output logic             pxVld,
    input  logic             pxRdy,
    output logic             pxFirst,
    output logic             pxLast,
    output logic [15:0]      winCnt
);

    localparam int WIN_LEN = CHUNK_LEN * CHUNKS_PER_WIN;
    localparam int IDX_W   = $clog2(WIN_LEN);

    typedef enum logic [1:0] {
        C_WAIT,
        C_ACK,
        C_GAP
    } capState_t;

    capState_t        state;
    capState_t        stateNext;
    logic [2:0]       chunkIdx;
    logic             wrBuf;
    logic             rdBuf;
    logic [1:0]       full;
    logic [IDX_W-1:0] rdIdx;
    logic [IDX_W-1:0] wrBase;
    logic             accept;
    logic             lastChunk;
    logic             rdAccept;
    logic             rdLast;

    logic [PIX_W-1:0] winBuf [2][WIN_LEN];

    assign accept    = (state == C_ACK);
    assign lastChunk = (chunkIdx == 3'(CHUNKS_PER_WIN - 1));
    assign rdAccept  = pxVld && pxRdy;
    assign rdLast    = (rdIdx == IDX_W'(WIN_LEN - 1));
    assign wrBase    = IDX_W'(chunkIdx) * IDX_W'(CHUNK_LEN);

    // vldIpgu is only looked at in C_WAIT: the IPGU drops it during the
    // accept cycle, so the capture edge must not depend on it.
    always_comb begin
        stateNext = state;
        case (state)
            C_WAIT:  if (vldIpgu && !full[wrBuf]) stateNext = C_ACK;
            C_ACK:   stateNext = C_GAP;
            C_GAP:   stateNext = C_WAIT;
            default: stateNext = C_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= C_WAIT;
            rdyHeu   <= 1'b0;
            chunkIdx <= '0;
            wrBuf    <= 1'b0;
            rdBuf    <= 1'b0;
            full     <= '0;
            rdIdx    <= '0;
            winCnt   <= '0;
        end else if (flush) begin
            // C_GAP keeps a stale vldIpgu from being accepted right away
            state    <= C_GAP;
            rdyHeu   <= 1'b0;
            chunkIdx <= '0;
            wrBuf    <= 1'b0;
            rdBuf    <= 1'b0;
            full     <= '0;
            rdIdx    <= '0;
            winCnt   <= '0;
        end else begin
            state  <= stateNext;
            rdyHeu <= (stateNext == C_ACK);

            if (accept) begin
                if (lastChunk) begin
                    chunkIdx     <= '0;
                    full[wrBuf]  <= 1'b1;
                    wrBuf        <= ~wrBuf;
                end else begin
                    chunkIdx <= chunkIdx + 3'd1;
                end
            end

            // The capture side only writes a buffer that was free, so the
            // two full[] updates never target the same bit.
            if (rdAccept) begin
                if (rdLast) begin
                    full[rdBuf] <= 1'b0;
                    rdBuf       <= ~rdBuf;
                    rdIdx       <= '0;
                    winCnt      <= winCnt + 16'd1;
                end else begin
                    rdIdx <= rdIdx + IDX_W'(1);
                end
            end
        end
    end

    // Pixel storage carries no reset; validity is tracked by full[].
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < CHUNK_LEN; i++) begin
                winBuf[wrBuf][wrBase + IDX_W'(i)] <= ipguOutBufferQ[i];
            end
        end
    end

    assign pxVld   = full[rdBuf];
    assign pxOut   = pxVld ? winBuf[rdBuf][rdIdx] : '0;
    assign pxFirst = pxVld && (rdIdx == '0);
    assign pxLast  = pxVld && rdLast;

endmodule

// File: tb/tb_heu_win_rx.sv
module tb_heu_win_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        vldIpgu;
    logic [7:0]  q [79:0];
    logic        rdyHeu;
    logic        flush;
    logic [7:0]  pxOut;
    logic        pxVld;
    logic        pxRdy;
    logic        pxFirst;
    logic        pxLast;
    logic [15:0] winCnt;

    heu_win_rx dut (
        .clk            (clk),
        .rst            (rst),
        .vldIpgu        (vldIpgu),
        .ipguOutBufferQ (q),
        .rdyHeu         (rdyHeu),
        .flush          (flush),
        .pxOut          (pxOut),
        .pxVld          (pxVld),
        .pxRdy          (pxRdy),
        .pxFirst        (pxFirst),
        .pxLast         (pxLast),
        .winCnt         (winCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] px;
        logic       first;
        logic       last;
    } exp_t;

    exp_t expQ [$];

    int nPass = 0;
    int nTot  = 0;
    int cyc   = 0;
    int pulses = 0;
    int accCnt = 0;
    int firstCyc = 0;
    int lastCyc  = 0;
    logic       prevRdy   = 1'b0;
    logic       stallPrev = 1'b0;
    logic [7:0] prevOut   = 8'd0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        nTot++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops the scoreboard on every accepted pixel.
    always @(negedge clk) begin
        if (!rst) begin
            if (rdyHeu) begin
                check("rdyHeu single cycle", int'(prevRdy), 0);
                pulses++;
            end
            if (pxVld && stallPrev) check("pxOut hold in stall", int'(pxOut), int'(prevOut));
            if (pxVld && pxRdy) begin
                if (expQ.size() == 0) begin
                    check("unexpected pixel", 0, 1);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    check("pxOut", int'(pxOut), int'(e.px));
                    check("pxFirst", int'(pxFirst), int'(e.first));
                    check("pxLast", int'(pxLast), int'(e.last));
                end
                if (pxFirst) firstCyc = cyc;
                if (pxLast) lastCyc = cyc;
                accCnt++;
            end
            prevRdy   = rdyHeu;
            stallPrev = pxVld && !pxRdy;
            prevOut   = pxOut;
        end else begin
            prevRdy   = 1'b0;
            stallPrev = 1'b0;
        end
    end

    task automatic pushWin(input int seed);
        for (int i = 0; i < 400; i++) begin
            exp_t e;
            e.px    = 8'(seed + i);
            e.first = (i == 0);
            e.last  = (i == 399);
            expQ.push_back(e);
        end
    endtask

    task automatic sendChunk(input int seed, input int c);
        int got;
        got = 0;
        for (int i = 0; i < 80; i++) q[i] = 8'(seed + c * 80 + i);
        vldIpgu = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (rdyHeu) begin
                got = 1;
                break;
            end
        end
        check("chunk accepted", got, 1);
        vldIpgu = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic sendWin(input int seed);
        pushWin(seed);
        for (int c = 0; c < 5; c++) sendChunk(seed, c);
    endtask

    task automatic waitWinCnt(input int target, input string name);
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (int'(winCnt) == target) break;
        end
        check(name, int'(winCnt), target);
    endtask

    initial begin
        int p0;
        int aLast;
        int got;

        rst = 1'b1; vldIpgu = 1'b0; flush = 1'b0; pxRdy = 1'b0;
        for (int i = 0; i < 80; i++) q[i] = 8'd0;
        #1;
        check("reset rdyHeu", int'(rdyHeu), 0);
        check("reset pxVld", int'(pxVld), 0);
        check("reset pxOut", int'(pxOut), 0);
        check("reset pxFirst", int'(pxFirst), 0);
        check("reset pxLast", int'(pxLast), 0);
        check("reset winCnt", int'(winCnt), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single window at full rate
        pxRdy = 1'b1;
        sendWin(0);
        waitWinCnt(1, "single window winCnt");
        check("single window pulses", pulses, 5);
        check("single window span", lastCyc - firstCyc, 399);

        // output stall: pxRdy alternates every cycle
        pxRdy = 1'b0;
        sendWin(37);
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            pxRdy = ~pxRdy;
            if (winCnt == 16'd2) break;
        end
        pxRdy = 1'b1;
        check("stall winCnt", int'(winCnt), 2);
        check("stall span", lastCyc - firstCyc, 798);

        // concurrent: window B captured while A streams
        sendWin(91);
        sendWin(150);
        waitWinCnt(3, "concurrent first winCnt");
        aLast = lastCyc;
        waitWinCnt(4, "concurrent second winCnt");
        check("no bubble between windows", firstCyc, aLast + 1);

        // backpressure: both buffers fill, 11th chunk must stall
        pxRdy = 1'b0;
        p0 = pulses;
        sendWin(200);
        sendWin(13);
        for (int i = 0; i < 80; i++) q[i] = 8'(99 + i);
        vldIpgu = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("backpressure pulses", pulses - p0, 10);
        check("backpressure rdyHeu", int'(rdyHeu), 0);
        check("backpressure pxVld", int'(pxVld), 1);
        pxRdy = 1'b1;
        waitWinCnt(5, "backpressure drain winCnt");
        got = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (rdyHeu) begin
                got = 1;
                break;
            end
        end
        check("rdyHeu after buffer freed", got, 1);
        vldIpgu = 1'b0;
        @(posedge clk); #1;

        // partial window (3 chunks) then flush
        sendChunk(99, 1);
        sendChunk(99, 2);
        waitWinCnt(6, "backpressure second winCnt");
        repeat (5) @(posedge clk);
        #1;
        check("partial window hidden", int'(pxVld), 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush winCnt", int'(winCnt), 0);
        check("flush pxVld", int'(pxVld), 0);
        check("flush rdyHeu", int'(rdyHeu), 0);
        sendWin(77);
        waitWinCnt(1, "post-flush winCnt");

        // async reset mid-stream at rdIdx=200
        accCnt = 0;
        sendWin(55);
        for (int k = 0; k < 1000; k++) begin
            if (accCnt >= 200) break;
            @(posedge clk); #1;
        end
        check("reached rdIdx 200", accCnt, 200);
        #1 rst = 1'b1;
        #1;
        check("async rst pxVld", int'(pxVld), 0);
        check("async rst pxOut", int'(pxOut), 0);
        check("async rst pxFirst", int'(pxFirst), 0);
        check("async rst winCnt", int'(winCnt), 0);
        check("async rst rdyHeu", int'(rdyHeu), 0);
        expQ.delete();
        p0 = pulses;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("no rdyHeu without vldIpgu", pulses - p0, 0);
        sendWin(120);
        waitWinCnt(1, "post-reset winCnt");
        check("scoreboard drained", expQ.size(), 0);

        $display("%0d/%0d checks passed", nPass, nTot);
        $finish;
    end

endmodule
